// File: rtl/card_game_pkg.sv
// card_game_pkg: shared state encoding, grid constants and card layout for the memory game
package card_game_pkg;

    typedef enum logic [1:0] {PICK1, PICK2, SHOW, DONE} state_t;

    localparam int GRID_DIM  = 4;
    localparam int NUM_CARDS = 16;
    localparam int NUM_PAIRS = 8;

    localparam logic [2:0] LAYOUT [NUM_CARDS] = '{
        3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd4,
        3'd6, 3'd0, 3'd4, 3'd3, 3'd7, 3'd2, 3'd5, 3'd1
    };

endpackage

// File: rtl/card_game_ctrl_if.sv
// card_game_ctrl_if: button pulses in, board state out, between input stage and game logic
interface card_game_ctrl_if;
    import card_game_pkg::*;

    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_left;
    logic                 btn_right;
    logic                 btn_sel;
    logic [3:0]           cursor;
    logic [NUM_CARDS-1:0] card_en;
    logic [NUM_CARDS-1:0] matched;
    logic [3:0]           pairs_found;
    logic [7:0]           tries;
    logic                 game_over;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel,
        input  cursor, card_en, matched, pairs_found, tries, game_over
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel,
        output cursor, card_en, matched, pairs_found, tries, game_over
    );

endinterface

// File: rtl/card_game_ctrl_cursor_nav.sv
// cursor_nav: registered {row,col} cursor with per-axis wrap and up>down>left>right priority
module cursor_nav (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       freeze,
    input  logic       clear,
    output logic [3:0] cursor
);

    logic [3:0] next;

    // 2-bit row/col arithmetic wraps naturally within the row or column
    always_comb
        next = up    ? {cursor[3:2] - 2'd1, cursor[1:0]} :
               down  ? {cursor[3:2] + 2'd1, cursor[1:0]} :
               left  ? {cursor[3:2], cursor[1:0] - 2'd1} :
               right ? {cursor[3:2], cursor[1:0] + 2'd1} : cursor;

    // clear (game restart) wins over freeze; otherwise move unless frozen
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cursor <= '0;
        else if (clear)
            cursor <= '0;
        else if (!freeze)
            cursor <= next;

endmodule

// File: rtl/card_game_ctrl.sv
// card_game_ctrl: pick-two / compare / hide-or-keep game logic for the 4x4 memory card game
module card_game_ctrl
    import card_game_pkg::*;
#(
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int TIMER_W     = 26
) (
    input logic             clk,
    input logic             reset,
    card_game_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);

    state_t               state_q, state_d;
    logic [NUM_CARDS-1:0] card_en_q, card_en_d;
    logic [NUM_CARDS-1:0] matched_q, matched_d;
    logic [3:0]           pairs_q, pairs_d;
    logic [7:0]           tries_q, tries_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           first_q, first_d;
    logic [3:0]           second_q, second_d;
    logic                 game_over_q;
    logic [3:0]           cursor;
    logic                 sel;
    logic                 valid;

    assign sel   = bus.btn_sel;
    assign valid = !card_en_q[cursor];

    cursor_nav u_nav (
        .clk    (clk),
        .reset  (reset),
        .up     (bus.btn_up),
        .down   (bus.btn_down),
        .left   (bus.btn_left),
        .right  (bus.btn_right),
        .freeze (state_q == DONE),
        .clear  (state_q == DONE && sel),
        .cursor (cursor)
    );

    // state and board registers; game_over is registered off the next state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q     <= PICK1;
            card_en_q   <= '0;
            matched_q   <= '0;
            pairs_q     <= '0;
            tries_q     <= '0;
            timer_q     <= '0;
            first_q     <= '0;
            second_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            card_en_q   <= card_en_d;
            matched_q   <= matched_d;
            pairs_q     <= pairs_d;
            tries_q     <= tries_d;
            timer_q     <= timer_d;
            first_q     <= first_d;
            second_q    <= second_d;
            game_over_q <= state_d == DONE;
        end

    // selects use the pre-move cursor; SHOW resolves the pair when the timer reaches zero
    always_comb begin
        state_d   = state_q;
        card_en_d = card_en_q;
        matched_d = matched_q;
        pairs_d   = pairs_q;
        tries_d   = tries_q;
        timer_d   = timer_q;
        first_d   = first_q;
        second_d  = second_q;
        case (state_q)
            PICK1:
                if (sel && valid) begin
                    card_en_d[cursor] = 1'b1;
                    first_d           = cursor;
                    state_d           = PICK2;
                end
            PICK2:
                if (sel && valid) begin
                    card_en_d[cursor] = 1'b1;
                    second_d          = cursor;
                    timer_d           = SHOW_LOAD;
                    tries_d           = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
                    state_d           = SHOW;
                end
            SHOW:
                if (timer_q == '0) begin
                    if (LAYOUT[first_q] == LAYOUT[second_q]) begin
                        matched_d[first_q]  = 1'b1;
                        matched_d[second_q] = 1'b1;
                        pairs_d             = pairs_q + 4'd1;
                        state_d             = (pairs_q == 4'(NUM_PAIRS - 1)) ? DONE : PICK1;
                    end else begin
                        card_en_d[first_q]  = 1'b0;
                        card_en_d[second_q] = 1'b0;
                        state_d             = PICK1;
                    end
                end else
                    timer_d = timer_q - 1'b1;
            DONE:
                if (sel) begin
                    card_en_d = '0;
                    matched_d = '0;
                    pairs_d   = '0;
                    tries_d   = '0;
                    state_d   = PICK1;
                end
        endcase
    end

    assign bus.cursor      = cursor;
    assign bus.card_en     = card_en_q;
    assign bus.matched     = matched_q;
    assign bus.pairs_found = pairs_q;
    assign bus.tries       = tries_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: doc/card_game_ctrl.md
Name: card_game_ctrl

Overview:
- Game-logic stage for the 4x4 memory card game; sits directly upstream of the 16 card renderer instances.
- Tracks the player cursor and runs the pick-two / compare / hide-or-keep sequence.
- Per-card face-up enables feed each renderer's enable input; the cursor drives the highlight overlay.
- Inputs are single-cycle, pre-debounced button pulses.

Parameters:
- SHOW_CYCLES, 50_000_000, cycles both picked cards stay visible before compare (1 s at 50 MHz); must be >= 1.
- TIMER_W, 26, width of the show timer; must hold SHOW_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_up  in  1  one-cycle pulse, move cursor up one row
- btn_down  in  1  one-cycle pulse, move cursor down one row
- btn_left  in  1  one-cycle pulse, move cursor left one column
- btn_right  in  1  one-cycle pulse, move cursor right one column
- btn_sel  in  1  one-cycle pulse, pick card under cursor / restart when done
- cursor  out  4  cursor position, {row[1:0], col[1:0]}, same encoding as renderer pos
- card_en  out  16  bit i = card i face-up (picked or matched)
- matched  out  16  bit i = card i permanently matched
- pairs_found  out  4  matched pairs, 0..8
- tries  out  8  completed two-card attempts, saturates at 255
- game_over  out  1  high while all 8 pairs are matched

Behaviour:
- Reset (async): cursor=0, card_en=0, matched=0, pairs_found=0, tries=0, game_over=0, timer=0, state=PICK1.
- All outputs are registered. An effect of a pulse is visible on the next rising edge.
- Cursor moves in PICK1, PICK2 and SHOW. It is frozen in DONE.
- Column moves wrap within the row (col 3 + right -> col 0). Row moves wrap within the column (row 0 + up -> row 3).
- Simultaneous direction pulses: only the highest-priority one applies (up > down > left > right).
- A card is valid when card_en[cursor]=0.
- When btn_sel and a direction pulse arrive together, the select uses the pre-move cursor. The move applies in the same cycle.
- PICK1: sel on a valid card sets card_en[cursor] and latches first=cursor, then -> PICK2. Sel on an invalid card is ignored.
- PICK2: sel on a valid card sets card_en[cursor], latches second=cursor, loads timer=SHOW_CYCLES-1, increments tries (saturating), then -> SHOW. Sel on an invalid card (including first) is ignored.
- SHOW: sel is ignored. Timer decrements each cycle. In the cycle where timer==0:
  - If LAYOUT[first]==LAYOUT[second]: set matched[first] and matched[second], keep card_en, pairs_found+1.
  - Otherwise: clear card_en[first] and card_en[second].
  - Next state is DONE if pairs_found becomes 8, else PICK1.
  - SHOW therefore lasts exactly SHOW_CYCLES cycles.
- DONE: game_over=1. Sel clears card_en, matched, pairs_found, tries and cursor, then -> PICK1 with game_over=0 on the next edge. Direction pulses are ignored.
- Reset asserted in any state (including mid-SHOW) returns immediately to the reset values. Partial picks are discarded.
- Invariant: matched is a subset of card_en. popcount(matched) = 2*pairs_found.

Decomposition:
- Shared package card_game_pkg holds:
  - state enum {PICK1, PICK2, SHOW, DONE}
  - GRID_DIM=4, NUM_CARDS=16, NUM_PAIRS=8
  - LAYOUT: 16 x 3-bit card IDs, positions 0..15 = 3,5,0,7,1,6,2,4,6,0,4,3,7,2,5,1
- The renderer ROM selection uses the same LAYOUT table.
- One sub-module, cursor_nav: registered cursor with wrap and direction priority. Inputs are the direction pulses and a freeze input. Output is the cursor.

Test Plan (SHOW_CYCLES=4):
- Reset, then right, right, down -> cursor=4'b0110. Up at row 0 (cursor=1) -> cursor=13. Left at col 0 (cursor=4) -> cursor=7.
- Match: sel at 0, sel at 11 -> card_en=16'h0801, tries=1. Exactly 4 cycles later matched=16'h0801, pairs_found=1, state PICK1.
- Mismatch: sel at 1, sel at 2 -> card_en bits 1,2 set for 4 cycles, then cleared. matched unchanged, tries increments.
- Ignore rules:
  - sel on the same card twice in PICK1/PICK2 -> second sel ignored, tries unchanged.
  - sel during SHOW -> no effect.
  - sel on a matched card -> ignored.
- Full game: pick all 8 pairs correctly -> pairs_found=8, game_over=1, card_en=matched=16'hFFFF, tries=8. Then sel -> all cleared, cursor=0, game_over=0.
- Async reset asserted mid-SHOW (timer=2) -> outputs zero immediately, without waiting for a clock edge. After release, state PICK1.
